ncl_mult3: RTL and testbench
============================

Name: ncl_mult3

Overview:
- Clocked model of a NULL Convention Logic (NCL) 3x3 unsigned multiplier with dual-rail inputs and outputs.
- Accepts two 3-bit dual-rail operands and produces a 6-bit dual-rail product.
- Alternates DATA and NULL wavefronts under a Ki/Ko completion handshake.
- Sits as one pipeline stage between a dual-rail producer (driven by Ko) and a consumer (returning Ki).

Parameters:
- none (fixed 3x3 -> 6 operand/product widths)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- Ai0_rail1/Ai0_rail0, Ai1_rail1/Ai1_rail0, Ai2_rail1/Ai2_rail0  in  1 each  operand A bits 0..2, dual-rail
- Bi0_rail1/Bi0_rail0, Bi1_rail1/Bi1_rail0, Bi2_rail1/Bi2_rail0  in  1 each  operand B bits 0..2, dual-rail
- Ki  in  1  consumer request: 1 = request DATA, 0 = request NULL
- Po0_rail1/Po0_rail0 .. Po5_rail1/Po5_rail0  out  1 each  product bits 0..5, dual-rail
- Ko  out  1  acknowledge to producer: 1 = ready for DATA, 0 = ready for NULL

Behaviour:
- Dual-rail encoding per bit:
  - 01 = DATA 0 (rail0 set)
  - 10 = DATA 1 (rail1 set)
  - 00 = NULL
  - 11 = illegal
- Input classification:
  - DATA-complete: all six input pairs are 01 or 10.
  - NULL-complete: all six input pairs are 00.
  - Anything else (partial, or any 11 pair): incomplete.
- Output register holds one wavefront (DATA or NULL); this is the hysteresis state of the NCL stage.
- On rising clk, in priority order:
  - DATA-complete and Ki=1 and output NULL: load product P = A*B (unsigned, 0..49). Po_k = 10 if P[k]=1, else 01.
  - NULL-complete and Ki=0 and output DATA: load all Po pairs = 00.
  - Otherwise: hold.
- Latency: one clk from the qualifying condition to the output update.
- Ko = NOT(output DATA-complete), registered together with Po:
  - Ko=1 while outputs are NULL.
  - Ko=0 while outputs hold DATA.
- Outputs never show a mixed or partial wavefront; all six pairs change on the same edge.
- Any 11 input pair blocks completion; state holds until the input becomes legal and complete.
- Ki mismatch (DATA-complete with Ki=0, or NULL-complete with Ki=1): hold.
- Reset:
  - rst=0 asynchronously forces all Po rails to 0 (NULL) and Ko=1.
  - Reset mid-DATA aborts the wavefront immediately.
  - First DATA is accepted on the first qualifying edge after rst deasserts.
- Product bit widths: P[5:0]. P[5]=1 only for products >= 32 (e.g. 6*6=36, 7*5=35, 7*7=49).
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: NCL_MULT3_ILLEGAL_CHK_EN
- Defined:
  - Adds output port err (1 bit), registered.
  - err is set on any rising clk where any input pair is 11.
  - err is sticky until rst asserts; reset value 0.
  - Datapath behaviour is unchanged.
- Undefined: no err port; illegal codes are only treated as incomplete.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> all Po rails 0, Ko=1, asynchronously without a clk edge; release rst, all inputs NULL -> unchanged.
- DATA: A=3, B=5, Ki=1 -> one clk later product 001111 (Po0..3 = 10, Po4..5 = 01), Ko=0. Then NULL inputs with Ki=0 -> one clk later all Po = 00, Ko=1.
- Boundaries:
  - A=0, B=0 -> product 000000, all pairs 01.
  - A=7, B=7 -> 110001 (49).
  - A=1, B=1 -> 000001.
  - Each case separated by a NULL wavefront.
- Incomplete input: only A0/B0 driven DATA, other pairs 00, Ki=1 -> outputs stay NULL, Ko stays 1 for 10 clks. Completing the remaining pairs -> product appears one clk later.
- Handshake hold:
  - DATA-complete inputs with Ki=0 -> hold NULL.
  - After DATA is latched, change inputs to different DATA -> outputs unchanged until the NULL cycle.
  - rst=0 mid-DATA -> immediate NULL, Ko=1.

Source files
------------

// File: rtl/ncl_mult3.sv
// Clocked NCL 3x3 dual-rail multiplier stage: one clk from a qualifying wavefront to Po/Ko, holds otherwise under Ki/Ko.
// Optional NCL_MULT3_ILLEGAL_CHK_EN adds a sticky registered err flag for any 11-coded input pair.
module ncl_mult3 (
   input  logic clk,
   input  logic rst,
   input  logic Ai0_rail1,
   input  logic Ai0_rail0,
   input  logic Ai1_rail1,
   input  logic Ai1_rail0,
   input  logic Ai2_rail1,
   input  logic Ai2_rail0,
   input  logic Bi0_rail1,
   input  logic Bi0_rail0,
   input  logic Bi1_rail1,
   input  logic Bi1_rail0,
   input  logic Bi2_rail1,
   input  logic Bi2_rail0,
   input  logic Ki,
   output logic Po0_rail1,
   output logic Po0_rail0,
   output logic Po1_rail1,
   output logic Po1_rail0,
   output logic Po2_rail1,
   output logic Po2_rail0,
   output logic Po3_rail1,
   output logic Po3_rail0,
   output logic Po4_rail1,
   output logic Po4_rail0,
   output logic Po5_rail1,
   output logic Po5_rail0,
`ifdef NCL_MULT3_ILLEGAL_CHK_EN
   output logic err,
`endif
   output logic Ko
);

   logic [5:0] in_rail1;
   logic [5:0] in_rail0;
   logic       data_cmp;
   logic       null_cmp;
   logic       illegal;
   logic [5:0] prod;
   logic [5:0] po_rail1;
   logic [5:0] po_rail0;
   logic       ko_q;

   assign in_rail1 = {Bi2_rail1, Bi1_rail1, Bi0_rail1, Ai2_rail1, Ai1_rail1, Ai0_rail1};
   assign in_rail0 = {Bi2_rail0, Bi1_rail0, Bi0_rail0, Ai2_rail0, Ai1_rail0, Ai0_rail0};

   // A pair is DATA only when exactly one rail is set; any 11 pair breaks both completions.
   assign data_cmp = &(in_rail1 ^ in_rail0);
   assign null_cmp = ~|(in_rail1 | in_rail0);
   assign illegal  = |(in_rail1 & in_rail0);

   assign prod = {3'b000, in_rail1[2:0]} * {3'b000, in_rail1[5:3]};

   // ko_q doubles as the stage state: 1 = output NULL, 0 = output DATA.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         po_rail1 <= 6'b000000;
         po_rail0 <= 6'b000000;
         ko_q     <= 1'b1;
      end else if (data_cmp && Ki && ko_q) begin
         po_rail1 <= prod;
         po_rail0 <= ~prod;
         ko_q     <= 1'b0;
      end else if (null_cmp && !Ki && !ko_q) begin
         po_rail1 <= 6'b000000;
         po_rail0 <= 6'b000000;
         ko_q     <= 1'b1;
      end
   end

`ifdef NCL_MULT3_ILLEGAL_CHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (illegal) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

   assign {Po5_rail1, Po4_rail1, Po3_rail1, Po2_rail1, Po1_rail1, Po0_rail1} = po_rail1;
   assign {Po5_rail0, Po4_rail0, Po3_rail0, Po2_rail0, Po1_rail0, Po0_rail0} = po_rail0;
   assign Ko = ko_q;

endmodule

// File: tb/tb_ncl_mult3.sv
// Bench for ncl_mult3: directed handshake/boundary steps then random wavefronts against an integer-level model.
module tb_ncl_mult3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ki = 1'b0;
   logic [1:0] a_code [3];
   logic [1:0] b_code [3];
   wire  [5:0] po_r1;
   wire  [5:0] po_r0;
   wire        ko;
`ifdef NCL_MULT3_ILLEGAL_CHK_EN
   wire        err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   bit m_data = 1'b0;
   int m_val  = 0;
   bit m_err  = 1'b0;

   always #5 clk = ~clk;

   ncl_mult3 dut (
      .clk(clk), .rst(rst),
      .Ai0_rail1(a_code[0][1]), .Ai0_rail0(a_code[0][0]),
      .Ai1_rail1(a_code[1][1]), .Ai1_rail0(a_code[1][0]),
      .Ai2_rail1(a_code[2][1]), .Ai2_rail0(a_code[2][0]),
      .Bi0_rail1(b_code[0][1]), .Bi0_rail0(b_code[0][0]),
      .Bi1_rail1(b_code[1][1]), .Bi1_rail0(b_code[1][0]),
      .Bi2_rail1(b_code[2][1]), .Bi2_rail0(b_code[2][0]),
      .Ki(ki),
      .Po0_rail1(po_r1[0]), .Po0_rail0(po_r0[0]),
      .Po1_rail1(po_r1[1]), .Po1_rail0(po_r0[1]),
      .Po2_rail1(po_r1[2]), .Po2_rail0(po_r0[2]),
      .Po3_rail1(po_r1[3]), .Po3_rail0(po_r0[3]),
      .Po4_rail1(po_r1[4]), .Po4_rail0(po_r0[4]),
      .Po5_rail1(po_r1[5]), .Po5_rail0(po_r0[5]),
`ifdef NCL_MULT3_ILLEGAL_CHK_EN
      .err(err),
`endif
      .Ko(ko)
   );

   task automatic set_data(input int a, input int b);
      for (int i = 0; i < 3; i++) begin
         a_code[i] = ((a >> i) & 1) != 0 ? 2'b10 : 2'b01;
         b_code[i] = ((b >> i) & 1) != 0 ? 2'b10 : 2'b01;
      end
   endtask

   task automatic set_null();
      for (int i = 0; i < 3; i++) begin
         a_code[i] = 2'b00;
         b_code[i] = 2'b00;
      end
   endtask

   // Model: classify the six pairs, decode operands as integers, then apply the wavefront rules.
   task automatic tick();
      int  n_data = 0;
      int  n_null = 0;
      bit  ill = 1'b0;
      int  av = 0;
      int  bv = 0;
      for (int i = 0; i < 3; i++) begin
         if (a_code[i] == 2'b01 || a_code[i] == 2'b10) n_data++;
         if (b_code[i] == 2'b01 || b_code[i] == 2'b10) n_data++;
         if (a_code[i] == 2'b00) n_null++;
         if (b_code[i] == 2'b00) n_null++;
         if (a_code[i] == 2'b11 || b_code[i] == 2'b11) ill = 1'b1;
         if (a_code[i] == 2'b10) av += (1 << i);
         if (b_code[i] == 2'b10) bv += (1 << i);
      end
      @(posedge clk);
      if (n_data == 6 && ki && !m_data) begin
         m_data = 1'b1;
         m_val  = av * bv;
      end else if (n_null == 6 && !ki && m_data) begin
         m_data = 1'b0;
      end
      if (ill) m_err = 1'b1;
      #1;
   endtask

   task automatic check(input string tag);
      logic [12:0] obs;
      logic [12:0] exp;
      logic [5:0]  p;
      p   = m_val[5:0];
      obs = {ko, po_r1, po_r0};
      exp = m_data ? {1'b0, p, ~p} : {1'b1, 12'h000};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
`ifdef NCL_MULT3_ILLEGAL_CHK_EN
      n_assert++;
      assert (err === m_err) else begin
         n_fail++;
         $error("FAIL %s_err observed=%b expected=%b", tag, err, m_err);
      end
`endif
   endtask

   task automatic data_then_null(input int a, input int b, input string tag);
      set_data(a, b);
      ki = 1'b1;
      tick();
      check(tag);
      set_null();
      ki = 1'b0;
      tick();
      check({tag, "_null"});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         a_code[i] = 2'($urandom_range(0, 3));
         b_code[i] = 2'($urandom_range(0, 3));
      end
      ki = 1'b1;
      #2 rst = 1'b0;
      m_data = 1'b0;
      m_err  = 1'b0;
      #1 check("reset_async");
      set_null();
      ki = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("release_null");

      data_then_null(3, 5, "data_3x5");
      data_then_null(0, 0, "bound_0x0");
      data_then_null(7, 7, "bound_7x7");
      data_then_null(1, 1, "bound_1x1");
      data_then_null(6, 6, "bound_6x6");
      data_then_null(7, 5, "bound_7x5");

      // Partial wavefront must not be captured.
      set_null();
      a_code[0] = 2'b10;
      b_code[0] = 2'b10;
      ki = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("incomplete_hold");
      end
      set_data(5, 6);
      tick();
      check("incomplete_done");

      set_data(2, 3);
      tick();
      check("data_change_hold");
      set_null();
      ki = 1'b0;
      tick();
      check("data_change_null");

      set_data(4, 4);
      ki = 1'b0;
      tick();
      check("ki_mismatch_hold");

      ki = 1'b1;
      tick();
      check("ki_match_data");
      set_null();
      tick();
      check("ki_mismatch_null");

      rst = 1'b0;
      m_data = 1'b0;
      m_err  = 1'b0;
      #1 check("reset_mid_data");
      ki = 1'b0;
      #1 rst = 1'b1;

      set_data(6, 3);
      a_code[1] = 2'b11;
      ki = 1'b1;
      tick();
      check("illegal_block");
      set_data(6, 3);
      tick();
      check("illegal_cleared");
      set_null();
      ki = 1'b0;
      tick();
      check("illegal_null");

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 3))
            0: set_data(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            1: set_null();
            2: begin
               for (int i = 0; i < 3; i++) begin
                  a_code[i] = 2'($urandom_range(0, 3));
                  b_code[i] = 2'($urandom_range(0, 3));
               end
            end
            default: ;
         endcase
         ki = ($urandom_range(0, 3) != 0) ? ~ko : ko;
         tick();
         check("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
